// File: rtl/shift_add_multiplier.sv
// Sequential 4x4 unsigned shift-add multiplier on a 4-bit ripple carry adder.
// start -> 4 add/shift iterations (busy) -> one-cycle done with registered product.

module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module ripple_carry_adder (
  input  logic [3:0] in_1,
  input  logic [3:0] in_2,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       c_out
);
  logic [4:0] c;

  assign c[0]  = c_in;
  assign c_out = c[4];

  for (genvar i = 0; i < 4; i++) begin : g_bit
    full_adder u_fa (
      .a_i (in_1[i]),
      .b_i (in_2[i]),
      .c_i (c[i]),
      .s_o (sum[i]),
      .c_o (c[i+1])
    );
  end
endmodule

module shift_add_multiplier (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] multiplicand,
  input  logic [3:0] multiplier,
  output logic       busy,
  output logic       done,
  output logic [7:0] product
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0] state_q, state_d;
  logic [3:0] acc_q, acc_d;
  logic [3:0] q_q, q_d;
  logic [3:0] a_q;
  logic [1:0] count_q;
  logic [7:0] product_q;

  logic [3:0] add_in2, add_sum;
  logic       add_c;

  assign add_in2 = q_q[0] ? a_q : 4'h0;

  ripple_carry_adder u_rca (
    .in_1  (acc_q),
    .in_2  (add_in2),
    .c_in  (1'b0),
    .sum   (add_sum),
    .c_out (add_c)
  );

  // The adder carry becomes the new acc MSB; the shifted-out sum LSB enters Q.
  assign acc_d = {add_c, add_sum[3:1]};
  assign q_d   = {add_sum[0], q_q[3:1]};

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = start ? RUN : IDLE;
      RUN:     state_d = (count_q == 2'd3) ? DONE : RUN;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= 4'h0;
      q_q       <= 4'h0;
      a_q       <= 4'h0;
      count_q   <= 2'd0;
      product_q <= 8'h00;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          a_q     <= multiplicand;
          q_q     <= multiplier;
          acc_q   <= 4'h0;
          count_q <= 2'd0;
        end
        RUN: begin
          acc_q   <= acc_d;
          q_q     <= q_d;
          count_q <= count_q + 2'd1;
          if (count_q == 2'd3) product_q <= {acc_d, q_d};
        end
        default: ;
      endcase
    end
  end

  assign product = product_q;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier: directed latency/handshake cases,
// random operands and an exhaustive back-to-back sweep against plain a*b.

module tb_shift_add_multiplier;
  logic       clk = 1'b0;
  logic       rst, start;
  logic [3:0] multiplicand, multiplier;
  logic       busy, done;
  logic [7:0] product;

  int tests = 0;
  int fails = 0;

  shift_add_multiplier dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are examined 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full multiply from IDLE with cycle-exact handshake checks.
  task automatic do_mul(input logic [3:0] a, input logic [3:0] b, input string tag);
    logic [7:0] exp_p;
    logic [7:0] prev_p;
    exp_p  = 8'(a) * 8'(b);
    prev_p = product;
    start = 1'b1; multiplicand = a; multiplier = b;
    step();
    start = 1'b0;
    multiplicand = 4'($urandom); multiplier = 4'($urandom);
    for (int i = 0; i < 4; i++) begin
      chk({tag, " busy"}, {31'd0, busy}, 32'd1);
      chk({tag, " done_lo"}, {31'd0, done}, 32'd0);
      chk({tag, " prod_stable"}, {24'd0, product}, {24'd0, prev_p});
      step();
    end
    chk({tag, " done"}, {31'd0, done}, 32'd1);
    chk({tag, " busy_lo"}, {31'd0, busy}, 32'd0);
    chk({tag, " product"}, {24'd0, product}, {24'd0, exp_p});
    step();
    chk({tag, " done_end"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    logic [7:0] pair_q[$];
    logic [7:0] pr;
    int n_done, last_done, cyc, idx, dones;
    logic prev_busy;

    rst = 1'b1; start = 1'b0; multiplicand = 4'h0; multiplier = 4'h0;
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst busy", {31'd0, busy}, 32'd0);
      chk("rst done", {31'd0, done}, 32'd0);
      chk("rst product", {24'd0, product}, 32'd0);
    end

    do_mul(4'd15, 4'd15, "15x15");
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hold E1", {24'd0, product}, 32'hE1);
      chk("hold idle", {30'd0, busy, done}, 32'd0);
    end
    do_mul(4'd13, 4'd11, "13x11");
    do_mul(4'd0,  4'd9,  "0x9");
    do_mul(4'd9,  4'd6,  "9x6");
    for (int i = 0; i < 8; i++) do_mul(4'($urandom), 4'($urandom), "rand");

    // Second start during busy must be ignored.
    start = 1'b1; multiplicand = 4'd3; multiplier = 4'd5;
    step();
    start = 1'b0;
    step();
    start = 1'b1; multiplicand = 4'd7; multiplier = 4'd7;
    step();
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) begin
        dones++;
        chk("ignored start product", {24'd0, product}, 32'h0F);
      end
      step();
    end
    chk("ignored start one done", dones, 1);

    // Reset in the 3rd busy cycle discards the multiply.
    start = 1'b1; multiplicand = 4'd12; multiplier = 4'd12;
    step();
    start = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst busy", {31'd0, busy}, 32'd0);
    chk("midrst product", {24'd0, product}, 32'd0);
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) dones++;
      step();
    end
    chk("midrst no done", dones, 0);
    do_mul(4'd2, 4'd3, "2x3");

    // Exhaustive sweep with start held high.
    idx = 0; n_done = 0; last_done = -1; cyc = 0; prev_busy = busy;
    start = 1'b1; {multiplicand, multiplier} = 8'd0;
    while (n_done < 256 && cyc < 2000) begin
      step();
      cyc++;
      if (busy && !prev_busy) begin
        pair_q.push_back(8'(idx));
        idx++;
        if (idx < 256) {multiplicand, multiplier} = 8'(idx);
        else start = 1'b0;
      end
      if (done) begin
        if (pair_q.size() == 0) begin
          chk("sweep stray done", 32'd1, 32'd0);
        end else begin
          pr = pair_q.pop_front();
          chk("sweep product", {24'd0, product}, {24'd0, 8'(pr[7:4]) * 8'(pr[3:0])});
        end
        if (last_done >= 0) chk("sweep spacing", cyc - last_done, 6);
        last_done = cyc;
        n_done++;
      end
      prev_busy = busy;
    end
    start = 1'b0;
    chk("sweep done count", n_done, 256);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
